fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fixed-latency floating-point multiplier between NREQ requesters.
- Accepts one operation at a time and drives the shared unit's val/a/b/roundingMode, holding operands stable until done.
- Captures the result and exception flags, then returns them to the granting requester over a valid/ready response channel.
- Sits between compute lanes and a single multiplier instance; the multiplier itself is external and connected through the mul_* ports.

Parameters:
- NREQ, 4, number of requesters (>=2).
- EXPW, 8, exponent width of operands.
- SIGW, 24, significand width of operands; word width W = EXPW+SIGW.
- TIMEOUT, 16, maximum cycles spent waiting for mul_done before aborting the operation.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  NREQ*W  operand a, packed, requester i at [i*W +: W]
- req_b  in  NREQ*W  operand b, packed, same layout as req_a
- req_rm  in  NREQ*3  rounding mode, packed
- resp_valid  out  NREQ  per-requester response valid, one-hot or zero
- resp_ready  in  NREQ  per-requester response accept
- resp_out  out  W  product, shared by all requesters
- resp_flags  out  5  exception flags, shared by all requesters
- mul_val  out  1  issue pulse to multiplier
- mul_a  out  W  operand a to multiplier
- mul_b  out  W  operand b to multiplier
- mul_rm  out  3  rounding mode to multiplier
- mul_out  in  W  multiplier result
- mul_flags  in  5  multiplier exception flags
- mul_done  in  1  multiplier completion
- timeout_err  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset values:
  - FSM goes to IDLE; all outputs are 0.
  - Round-robin pointer ptr = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching from (ptr+1) mod NREQ upward with wrap-around.
  - req_ready[g] = 1 combinationally in that cycle only.
  - Latch req_a/req_b/req_rm of g into operand regs and latch g into grant reg; go to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE:
  - mul_val = 1 for exactly one cycle; mul_a/mul_b/mul_rm come from the operand regs.
  - Clear the wait counter; go to WAIT.
- WAIT:
  - mul_val = 0; mul_a/mul_b/mul_rm stay held.
  - Counter increments each cycle.
  - On mul_done: capture mul_out/mul_flags into the result regs and go to RESP.
  - If the counter reaches TIMEOUT-1 with no mul_done: result = 0, flags = 5'b00001, set timeout_err, go to RESP.
  - If mul_done arrives in the same cycle the timeout fires, the done takes priority and no error is raised.
- RESP:
  - resp_valid[g] = 1, with resp_out/resp_flags taken from the result regs.
  - Held until resp_ready[g]; then ptr <= g and go to IDLE.
- Latency with the nominal 4-cycle multiplier: accept → ISSUE (1) → done 4 cycles after mul_val → RESP, so resp_valid asserts 6 cycles after the accept cycle.
- Throughput: at most one outstanding operation; the next accept is earliest in the cycle after the resp handshake.
- Requests are only accepted in IDLE; req_ready is 0 in every other state.
- req_valid dropping before acceptance is legal and causes no grant.
- Operands are sampled only at accept; changes afterwards are ignored.
- mul_done outside WAIT is ignored.
- resp_ready on non-granted lanes is ignored.
- Reset mid-operation: the FSM returns to IDLE; the in-flight result and any pending response are discarded.

Decomposition:
- Package fp_mul_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - FLAG_INVALID = 5'b10000, FLAG_INEXACT = 5'b00001
  - TIMEOUT_FLAGS constant
  - helper function clog2 for the counter and grant index widths
- Sub-module rr_picker(NREQ): combinational round-robin picker.
  - Inputs: request vector, ptr.
  - Outputs: one-hot grant, grant index, any flag.
- The FSM, operand/result regs and counter stay in the top module.

Test Plan:
- Single request: requester 0 sends 0x40000000 × 0x40400000, rm=0; bench multiplier model with 4-cycle done → resp_valid[0] exactly 6 cycles after accept, resp_out=0x40C00000, resp_flags=0.
- All four req_valid held high with distinct operands → grants occur in order 0,1,2,3,0; no requester is granted twice before all the others.
- Backpressure: resp_ready[1] held low for 10 cycles → resp_valid[1] and resp_out stay stable, req_ready stays 0 throughout, and the next grant follows the handshake.
- Timeout: model never asserts mul_done → after TIMEOUT cycles in WAIT, resp_out=0, resp_flags=5'b00001, timeout_err=1 and remains set through later ops.
- Same-cycle done and timeout at counter TIMEOUT-1 → resp carries mul_out, timeout_err stays 0.
- Reset asserted during WAIT → all outputs 0 next cycle; a subsequent request from requester 2 alone is granted and completes normally.

Source files
------------

// File: rtl/fp_mul_arb_pkg.sv
// fp_mul_arb_pkg: shared types, flag constants and width helper for the multiplier arbiter
package fp_mul_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [4:0] FLAG_INVALID = 5'b10000;
  localparam logic [4:0] FLAG_INEXACT = 5'b00001;
  localparam logic [4:0] TIMEOUT_FLAGS = FLAG_INEXACT;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r < 1 ? 1 : r;
  endfunction
endpackage

// File: rtl/fp_mul_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker, first request above ptr with wrap-around
module rr_picker
  import fp_mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  always_comb begin
    idx = '0;
    any = |req;
    // walk from furthest to nearest so the nearest request after ptr wins
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(ptr) + k) % NREQ]) idx = IW'((int'(ptr) + k) % NREQ);
    grant = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sequencer sharing one fixed-latency FP multiplier between NREQ lanes
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int EXPW = 8,
  parameter int SIGW = 24,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*(EXPW+SIGW)-1:0] req_a,
  input  logic [NREQ*(EXPW+SIGW)-1:0] req_b,
  input  logic [NREQ*3-1:0]      req_rm,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [EXPW+SIGW-1:0]   resp_out,
  output logic [4:0]             resp_flags,
  output logic                   mul_val,
  output logic [EXPW+SIGW-1:0]   mul_a,
  output logic [EXPW+SIGW-1:0]   mul_b,
  output logic [2:0]             mul_rm,
  input  logic [EXPW+SIGW-1:0]   mul_out,
  input  logic [4:0]             mul_flags,
  input  logic                   mul_done,
  output logic                   timeout_err
);
  localparam int W = EXPW + SIGW;
  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(TIMEOUT);
  state_t state, state_nx;
  logic [IW-1:0] ptr, gnt, pick_idx;
  logic [NREQ-1:0] pick;
  logic pick_any, timed_out;
  logic [W-1:0] op_a, op_b, res;
  logic [2:0] op_rm;
  logic [4:0] res_flags;
  logic [CW-1:0] cnt;
  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req(req_valid), .ptr(ptr), .grant(pick), .idx(pick_idx), .any(pick_any)
  );
  assign timed_out = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (pick_any ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? ((mul_done || timed_out) ? RESP : WAIT) :
                                (resp_ready[gnt] ? IDLE : RESP);
    req_ready = state == IDLE ? pick : '0;
    resp_valid = state == RESP ? NREQ'(1) << gnt : '0;
    mul_val = state == ISSUE;
    mul_a = op_a;
    mul_b = op_b;
    mul_rm = op_rm;
    resp_out = res;
    resp_flags = res_flags;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= IW'(NREQ - 1);
      gnt <= '0;
      op_a <= '0;
      op_b <= '0;
      op_rm <= '0;
      res <= '0;
      res_flags <= '0;
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && pick_any) begin
        gnt <= pick_idx;
        op_a <= req_a[int'(pick_idx)*W +: W];
        op_b <= req_b[int'(pick_idx)*W +: W];
        op_rm <= req_rm[int'(pick_idx)*3 +: 3];
      end
      if (state == ISSUE) cnt <= '0;
      // a done in the final timeout cycle wins over the abort
      if (state == WAIT) begin
        cnt <= cnt + CW'(1);
        if (mul_done) begin
          res <= mul_out;
          res_flags <= mul_flags;
        end else if (timed_out) begin
          res <= '0;
          res_flags <= TIMEOUT_FLAGS;
          timeout_err <= 1'b1;
        end
      end
      if (state == RESP && resp_ready[gnt]) ptr <= gnt;
    end
  end
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: scoreboard bench with a programmable-latency lookup multiplier model
module tb_fp_mul_arbiter;
  localparam int NREQ = 4, W = 32, TIMEOUT = 16;
  logic clk = 0, reset = 1;
  logic [NREQ-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*3-1:0] req_rm;
  logic [W-1:0] resp_out, mul_a, mul_b, mul_out;
  logic [4:0] resp_flags, mul_flags;
  logic [2:0] mul_rm;
  logic mul_val, mul_done, timeout_err;
  always #5 clk = ~clk;
  fp_mul_arbiter #(.NREQ(NREQ), .EXPW(8), .SIGW(24), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_out(resp_out), .resp_flags(resp_flags),
    .mul_val(mul_val), .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm),
    .mul_out(mul_out), .mul_flags(mul_flags), .mul_done(mul_done), .timeout_err(timeout_err)
  );
  // hand-computed single-precision products
  logic [31:0] va[7] = '{32'h40000000, 32'h3F800000, 32'h40800000, 32'hBF800000, 32'h7F800000, 32'h3FC00000, 32'h3DCCCCCD};
  logic [31:0] vb[7] = '{32'h40400000, 32'h3F800000, 32'h3F000000, 32'h40A00000, 32'h00000000, 32'h3FC00000, 32'h41200000};
  logic [2:0]  vr[7] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd0, 3'd4, 3'd0};
  logic [31:0] vo[7] = '{32'h40C00000, 32'h3F800000, 32'h40000000, 32'hC0A00000, 32'h7FC00000, 32'h40100000, 32'h3F800000};
  logic [4:0]  vf[7] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b00001};
  function automatic logic [36:0] lookup(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    lookup = {32'hDEADBEEF, 5'h1F};
    for (int i = 0; i < 7; i++)
      if (a == va[i] && b == vb[i] && rm == vr[i]) lookup = {vo[i], vf[i]};
  endfunction
  assign {mul_out, mul_flags} = lookup(mul_a, mul_b, mul_rm);
  int dly = 4, mc = 0;
  logic busy = 0;
  assign mul_done = busy && dly != 0 && mc == dly;
  always @(posedge clk)
    if (reset) busy <= 0;
    else if (mul_val) begin busy <= 1; mc <= 1; end
    else if (busy) begin
      if (mul_done) busy <= 0;
      mc <= mc + 1;
    end
  typedef struct {int lane; logic [31:0] out; logic [4:0] flags; logic te; int lat; int acc;} exp_t;
  exp_t sb[$];
  int lane_q[NREQ][$];
  int grants[$], grant_cyc[$];
  int cyc = 0, checks = 0, errors = 0, hs_cyc = -1;
  logic te_model = 0;
  bit seen = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait budget expired", name);
  endtask
  // lane driver: records accepts into the scoreboard, then presents each lane's next vector
  initial begin
    int v;
    exp_t e;
    req_valid = '0; req_a = '0; req_b = '0; req_rm = '0;
    forever begin
      @(negedge clk);
      if (!reset)
        for (int i = 0; i < NREQ; i++)
          if (req_valid[i] && req_ready[i]) begin
            v = lane_q[i][0];
            if (dly == 0) te_model = 1;
            e.lane = i;
            e.out = dly == 0 ? 32'h0 : vo[v];
            e.flags = dly == 0 ? 5'b00001 : vf[v];
            e.te = te_model;
            e.lat = (dly == 0 || dly == 16) ? 18 : dly + 2;
            e.acc = cyc;
            sb.push_back(e);
            grants.push_back(i);
            grant_cyc.push_back(cyc);
            void'(lane_q[i].pop_front());
          end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = lane_q[i].size() > 0;
        if (req_valid[i]) begin
          v = lane_q[i][0];
          req_a[i*W +: W] = va[v];
          req_b[i*W +: W] = vb[v];
          req_rm[i*3 +: 3] = vr[v];
        end else begin
          req_a[i*W +: W] = $urandom;
          req_b[i*W +: W] = $urandom;
        end
      end
    end
  end
  // monitor: checks latency on first sight and payload at each handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) seen = 0;
      else if (resp_valid != 0) begin
        if (sb.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'h0);
        else begin
          e = sb[0];
          if (!seen) begin
            seen = 1;
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          end
          if ((resp_valid & resp_ready) != 0) begin
            chk("resp_lane", 64'(resp_valid), 64'(1 << e.lane));
            chk("resp_out", 64'(resp_out), 64'(e.out));
            chk("resp_flags", 64'(resp_flags), 64'(e.flags));
            chk("timeout_err", 64'(timeout_err), 64'(e.te));
            void'(sb.pop_front());
            seen = 0;
            hs_cyc = cyc;
          end
        end
      end
    end
  end
  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = sb.size() == 0;
      for (int i = 0; i < NREQ; i++) if (lane_q[i].size() != 0) ok = 0;
    end
    if (!ok) timeout_fail(name);
    @(posedge clk);
    #1;
  endtask
  int ord[5] = '{0, 1, 2, 3, 0};
  initial begin
    int g0, n;
    logic [31:0] ro;
    resp_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_mul_val", 64'(mul_val), 64'h0);
    chk("rst_mul_a", 64'(mul_a), 64'h0);
    chk("rst_resp_out", 64'(resp_out), 64'h0);
    chk("rst_timeout_err", 64'(timeout_err), 64'h0);
    reset = 0;
    g0 = grants.size();
    lane_q[0] = '{0, 4}; lane_q[1] = '{1}; lane_q[2] = '{2}; lane_q[3] = '{3};
    wait_done("all_four");
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), 64'(grants[g0 + k]), 64'(ord[k]));
    lane_q[0] = '{0};
    wait_done("single");
    resp_ready[1] = 0;
    lane_q[1] = '{5}; lane_q[2] = '{6};
    n = 0;
    while (!resp_valid[1] && n < 50) begin @(negedge clk); n++; end
    if (!resp_valid[1]) timeout_fail("bp_resp");
    ro = resp_out;
    chk("bp_out", 64'(ro), 64'h40100000);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 64'h2);
      chk("bp_stable", 64'(resp_out), 64'(ro));
      chk("bp_req_ready", 64'(req_ready), 64'h0);
    end
    n = grants.size();
    @(posedge clk);
    #1;
    resp_ready[1] = 1;
    for (int k = 0; k < 20 && grants.size() <= n; k++) @(negedge clk);
    if (grants.size() <= n) timeout_fail("bp_next_grant");
    else begin
      chk("bp_next_lane", 64'(grants[n]), 64'h2);
      chk("bp_next_cycle", 64'(grant_cyc[n] - hs_cyc), 64'h1);
    end
    wait_done("backpressure");
    dly = 16;
    lane_q[3] = '{1};
    wait_done("done_at_timeout");
    dly = 0;
    lane_q[2] = '{2};
    wait_done("timeout");
    chk("sticky_err", 64'(timeout_err), 64'h1);
    dly = 4;
    lane_q[0] = '{3};
    wait_done("after_timeout");
    lane_q[1] = '{4};
    n = 0;
    while (!mul_val && n < 20) begin @(negedge clk); n++; end
    if (!mul_val) timeout_fail("rst_issue");
    repeat (2) @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    chk("mid_resp_valid", 64'(resp_valid), 64'h0);
    chk("mid_mul_val", 64'(mul_val), 64'h0);
    chk("mid_mul_ab", {mul_a, mul_b}, 64'h0);
    chk("mid_resp", 64'({resp_out, resp_flags}), 64'h0);
    chk("mid_err", 64'(timeout_err), 64'h0);
    sb.delete();
    te_model = 0;
    seen = 0;
    reset = 0;
    n = grants.size();
    lane_q[2] = '{6};
    wait_done("after_reset");
    chk("post_rst_lane", 64'(grants[n]), 64'h2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
